qqspi_arbiter: RTL and testbench
================================

Name: qqspi_arbiter

Overview:
- Shares the single qqspi quad-SPI controller (PSRAM + NOR flash on one bus) between two bus masters: requester 0 (CPU data/instruction port) and requester 1 (DMA/framebuffer reader).
- Decodes the target device, converts byte addresses to qqspi word addresses, arbitrates round-robin and sequences one transaction at a time.
- Rejects illegal accesses with a fault response.
- Sits between the masters and qqspi, replacing the ad-hoc valid gating in the SoC top.

Parameters:
- NOR_BASE, 32'h2000_0000, NOR flash window base (byte address).
- NOR_SIZE, 32'h0100_0000, NOR window size in bytes (16 MiB).
- PSRAM_BASE, 32'h8000_0000, PSRAM window base.
- PSRAM_SIZE, 32'h0080_0000, PSRAM window size in bytes (8 MiB).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  2  per-requester request; held high until matching req_ready
- req_addr0 / req_addr1  in  32 each  byte address
- req_wdata0 / req_wdata1  in  32 each  write data
- req_wstrb0 / req_wstrb1  in  4 each  byte strobes; 0 = read
- req_ready  out  2  one-cycle completion pulse per requester
- req_fault  out  2  qualifies req_ready: access rejected
- req_rdata  out  32  read data, valid with req_ready
- mem_valid  out  1  to qqspi valid
- mem_addr  out  23  to qqspi addr, word address {1'b0, offset[23:2]}
- mem_wdata  out  32  to qqspi wdata
- mem_wstrb  out  4  to qqspi wstrb
- mem_psram  out  1  to qqspi PSRAM_SPIFLASH (1 = PSRAM)
- mem_ready  in  1  from qqspi ready (single-cycle pulse)
- mem_rdata  in  32  from qqspi rdata
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-low on resetn.
  - On reset: state=IDLE, rr_last=1 (requester 0 wins the first tie), and all latched fields are 0.
  - On reset: mem_valid, req_ready, req_fault and busy are 0; req_rdata=0.
- States: IDLE, ISSUE, FAULT, DONE.
- IDLE:
  - If any req_valid is set, grant by round-robin. If both are set, grant !rr_last; otherwise grant the single requester.
  - Latch the granted requester's addr, wdata and wstrb, its target, and gnt. Set rr_last=gnt.
  - Decode: in NOR window → target NOR; in PSRAM window → target PSRAM; else unmapped.
  - NOR write (|wstrb) or unmapped → FAULT; otherwise → ISSUE.
  - Grant decision takes 1 cycle.
- ISSUE:
  - mem_valid = (state==ISSUE) && !mem_ready, combinational so qqspi never sees valid in its ready cycle.
  - mem_addr, mem_wdata, mem_wstrb and mem_psram come from latched registers and are stable for the whole state.
  - On mem_ready: req_ready[gnt]=1 (combinational, same cycle) and req_rdata=mem_rdata for reads (0 for writes); go to DONE.
  - No timeout: the state waits for mem_ready indefinitely.
- FAULT: req_ready[gnt]=1, req_fault[gnt]=1, req_rdata=0 for one cycle; go to DONE.
- DONE:
  - One dead cycle so the requester can drop req_valid; go to IDLE.
  - req_valid of the just-served requester is ignored in this cycle.
- Fixed latencies:
  - Minimum request-to-ready is 2 cycles plus the qqspi latency.
  - Fault latency is 2 cycles.
  - Back-to-back grants are spaced at least 3 cycles apart.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Simultaneous events:
  - A request arriving while another is in ISSUE waits; it does not affect the in-flight transaction.
  - A requester deasserting req_valid before ready is a protocol violation; no recovery is required.
  - Windows are non-overlapping; an address ≥ base+size is unmapped (exclusive upper bound).
- Width rules:
  - offset = addr - base (32-bit); mem_addr = {1'b0, offset[23:2]}.
  - addr[1:0] is ignored; alignment is the requester's responsibility.
- Reset mid-operation:
  - Resetn low in ISSUE forces IDLE next cycle with mem_valid=0.
  - qqspi shares resetn, so it resets in the same cycle.

Decomposition:
- Shared package (soc address map): NOR_BASE, NOR_SIZE, PSRAM_BASE, PSRAM_SIZE, the state encoding localparams, and the TGT_NOR/TGT_PSRAM constants.
- One sub-module, rr_arbiter2:
  - Combinational inputs: req[1:0] and last.
  - Combinational outputs: gnt and any.
  - It is instantiated once. The FSM, decode and datapath stay in qqspi_arbiter.

Test Plan:
- Read PSRAM: req0 reads 0x8000_0010; mock qqspi answers after 20 cycles with 0xDEAD_BEEF → mem_addr=23'h4, mem_psram=1, req_ready[0] pulses once, req_rdata=0xDEAD_BEEF.
- NOR read: req1 reads 0x2000_0104 → mem_psram=0, mem_addr=23'h41, correct data returned.
- Write fault: req0 writes 0x2000_0000 with wstrb=4'hF → no mem_valid ever; 2 cycles later req_ready[0]=1, req_fault[0]=1.
- Unmapped fault: req1 reads 0x8080_0000 → req_fault[1]=1.
- Fairness:
  - Both requesters are continuously valid for 6 transactions → grant order 0,1,0,1,0,1.
  - mem_valid is never high in a cycle where mem_ready=1.
  - At least 3 cycles separate consecutive grants.
- Reset mid-transaction: resetn=0 during ISSUE → next cycle state=IDLE; mem_valid, req_ready and busy are 0; the first grant after release goes to req0.

Source files
------------

// File: rtl/qqspi_arbiter_pkg.sv
// qqspi_arbiter_pkg
//   SoC address map for the shared quad-SPI bus (NOR flash + PSRAM), the
//   arbiter FSM state encoding, target selectors and the latched
//   transaction record.
//   No ports: imported by qqspi_arbiter_if and qqspi_arbiter.
package qqspi_arbiter_pkg;

    localparam logic [31:0] NOR_BASE   = 32'h2000_0000;
    localparam logic [31:0] NOR_SIZE   = 32'h0100_0000;
    localparam logic [31:0] PSRAM_BASE = 32'h8000_0000;
    localparam logic [31:0] PSRAM_SIZE = 32'h0080_0000;

    // Width of the qqspi word address
    localparam int MEM_AW = 23;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Value driven on qqspi PSRAM_SPIFLASH
    localparam logic TGT_NOR   = 1'b0;
    localparam logic TGT_PSRAM = 1'b1;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        wstrb;
        logic              psram;
    } txn_t;

endpackage

// File: rtl/qqspi_arbiter_if.sv
// qqspi_arbiter_if
//   Bundles the two requester ports and the qqspi-facing bus.
//   req_valid[1:0], req_addr0/1, req_wdata0/1, req_wstrb0/1 : requests
//   req_ready[1:0], req_fault[1:0], req_rdata               : responses
//   mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_psram    : to qqspi
//   mem_ready, mem_rdata                                    : from qqspi
//   slave  : arbiter view (serves requesters, drives qqspi)
//   master : environment view (requesters + qqspi model)
interface qqspi_arbiter_if;
    import qqspi_arbiter_pkg::*;

    logic [1:0]        req_valid;
    logic [31:0]       req_addr0;
    logic [31:0]       req_addr1;
    logic [31:0]       req_wdata0;
    logic [31:0]       req_wdata1;
    logic [3:0]        req_wstrb0;
    logic [3:0]        req_wstrb1;
    logic [1:0]        req_ready;
    logic [1:0]        req_fault;
    logic [31:0]       req_rdata;

    logic              mem_valid;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_psram;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_addr0, req_addr1, req_wdata0, req_wdata1,
               req_wstrb0, req_wstrb1, mem_ready, mem_rdata,
        output req_ready, req_fault, req_rdata,
               mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_psram
    );

    modport master (
        output req_valid, req_addr0, req_addr1, req_wdata0, req_wdata1,
               req_wstrb0, req_wstrb1, mem_ready, mem_rdata,
        input  req_ready, req_fault, req_rdata,
               mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_psram
    );

endinterface

// File: rtl/qqspi_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin grant, purely combinational.
//   req[1:0] : pending requests
//   last     : requester granted most recently
//   gnt      : index of the winner (valid when any=1)
//   any      : at least one request pending
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       any
);

    always_comb begin
        any = |req;
        // On a tie the requester not served last wins; otherwise the lone
        // requester wins (req[1] is 0 when only requester 0 is asking).
        if (req == 2'b11)
            gnt = ~last;
        else
            gnt = req[1];
    end

endmodule

// File: rtl/qqspi_arbiter.sv
// qqspi_arbiter
//   Shares one qqspi controller between requester 0 (CPU) and requester 1
//   (DMA). Decodes NOR/PSRAM windows, converts byte to word addresses,
//   arbitrates round-robin and runs one transaction at a time. NOR writes
//   and unmapped addresses get a fault response without touching qqspi.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : qqspi_arbiter_if.slave (requester and qqspi signals)
//   busy        : FSM is not in IDLE
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for a request; grant + decode + latch
//   ISSUE    | mem_valid to qqspi until mem_ready, then respond
//   FAULT    | one-cycle fault response to the granted requester
//   DONE     | dead cycle so the served requester can drop req_valid
module qqspi_arbiter
    import qqspi_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    qqspi_arbiter_if.slave   bus,
    output logic             busy
);

    logic [1:0]  state;
    logic        rr_last;
    logic        gnt;
    txn_t        txn_q;

    logic        arb_gnt;
    logic        arb_any;

    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic [31:0] nor_off;
    logic [31:0] psram_off;
    logic        hit_nor;
    logic        hit_psram;
    logic        dec_fault;
    logic [MEM_AW-1:0] dec_addr;

    logic        issue_done;
    logic [1:0]  gnt_vec;

    rr_arbiter2 u_rr (
        .req  (bus.req_valid),
        .last (rr_last),
        .gnt  (arb_gnt),
        .any  (arb_any)
    );

    always_comb begin
        sel_addr  = arb_gnt ? bus.req_addr1  : bus.req_addr0;
        sel_wdata = arb_gnt ? bus.req_wdata1 : bus.req_wdata0;
        sel_wstrb = arb_gnt ? bus.req_wstrb1 : bus.req_wstrb0;

        // Unsigned wrap makes one compare cover both window bounds.
        nor_off   = sel_addr - NOR_BASE;
        psram_off = sel_addr - PSRAM_BASE;
        hit_nor   = nor_off < NOR_SIZE;
        hit_psram = psram_off < PSRAM_SIZE;

        dec_addr  = hit_psram ? {1'b0, psram_off[23:2]} : {1'b0, nor_off[23:2]};
        dec_fault = !(hit_nor || hit_psram) || (hit_nor && (|sel_wstrb));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            rr_last <= 1'b1;
            gnt     <= 1'b0;
            txn_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt         <= arb_gnt;
                        rr_last     <= arb_gnt;
                        txn_q.addr  <= dec_addr;
                        txn_q.wdata <= sel_wdata;
                        txn_q.wstrb <= sel_wstrb;
                        txn_q.psram <= hit_psram ? TGT_PSRAM : TGT_NOR;
                        state       <= dec_fault ? ST_FAULT : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_ready)
                        state <= ST_DONE;
                end
                ST_FAULT: state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        issue_done = (state == ST_ISSUE) && bus.mem_ready;
        gnt_vec    = gnt ? 2'b10 : 2'b01;
    end

    // mem_valid drops in the ready cycle so qqspi never sees a fresh request
    // overlapping its completion.
    assign bus.mem_valid = (state == ST_ISSUE) && !bus.mem_ready;
    assign bus.mem_addr  = txn_q.addr;
    assign bus.mem_wdata = txn_q.wdata;
    assign bus.mem_wstrb = txn_q.wstrb;
    assign bus.mem_psram = txn_q.psram;

    assign bus.req_ready = (issue_done || (state == ST_FAULT)) ? gnt_vec : 2'b00;
    assign bus.req_fault = (state == ST_FAULT) ? gnt_vec : 2'b00;
    assign bus.req_rdata = (issue_done && (txn_q.wstrb == 4'h0)) ? bus.mem_rdata : 32'h0;

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_qqspi_arbiter.sv
module tb_qqspi_arbiter;

    typedef struct {
        logic [22:0] addr;
        logic        psram;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_exp_t;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic busy;

    qqspi_arbiter_if bus_if ();

    qqspi_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if.slave),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    mem_exp_t mem_q[$];
    rsp_t     rsp_q0[$];
    rsp_t     rsp_q1[$];
    int       order_q[$];
    int       total = 0;
    int       bad = 0;
    int       cyc = 0;
    int       mem_delay = 5;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic expect_mem(input logic [22:0] a, input logic ps, input logic [3:0] ws,
                              input logic [31:0] wd, input logic [31:0] rd);
        mem_exp_t e;
        e.addr = a; e.psram = ps; e.wstrb = ws; e.wdata = wd; e.rdata = rd;
        mem_q.push_back(e);
    endtask

    task automatic expect_rsp(input int r, input logic f, input logic [31:0] rd);
        rsp_t e;
        e.fault = f; e.rdata = rd;
        if (r == 0) rsp_q0.push_back(e);
        else        rsp_q1.push_back(e);
    endtask

    // Starts and ends at negedge+1; lat counts cycles from the cycle
    // req_valid is first seen up to and including the ready cycle.
    task automatic req_txn(input int r, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, output int lat);
        int waits;
        bit got;
        waits = 0;
        got = 0;
        if (r == 0) begin
            bus_if.req_addr0 = a; bus_if.req_wdata0 = wd; bus_if.req_wstrb0 = ws;
        end else begin
            bus_if.req_addr1 = a; bus_if.req_wdata1 = wd; bus_if.req_wstrb1 = ws;
        end
        bus_if.req_valid[r] = 1'b1;
        while (!got && waits < 300) begin
            @(negedge clk);
            #1;
            waits++;
            if (bus_if.req_ready[r]) got = 1;
        end
        bus_if.req_valid[r] = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL req%0d_timeout: got=no_ready exp=ready addr=%h", r, a);
        end
        lat = waits + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // qqspi model: accepts mem_valid, checks it against the next expected
    // transaction and answers with a one-cycle mem_ready after mem_delay.
    initial begin : mock
        int cnt;
        bit active;
        mem_exp_t cur;
        active = 0;
        cnt = 0;
        cur.rdata = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                active = 0;
                bus_if.mem_ready = 1'b0;
                bus_if.mem_rdata = 32'h0;
            end else if (bus_if.mem_ready) begin
                bus_if.mem_ready = 1'b0;
                bus_if.mem_rdata = 32'h0;
                active = 0;
            end else if (active) begin
                cnt--;
                if (cnt <= 0) begin
                    bus_if.mem_ready = 1'b1;
                    bus_if.mem_rdata = cur.rdata;
                end
            end else if (bus_if.mem_valid) begin
                total++;
                if (mem_q.size() == 0) begin
                    bad++;
                    $display("FAIL mem_unexpected: got=valid addr=%h exp=no_valid", bus_if.mem_addr);
                    cur.rdata = 32'h0;
                end else begin
                    cur = mem_q.pop_front();
                    if (bus_if.mem_addr !== cur.addr || bus_if.mem_psram !== cur.psram ||
                        bus_if.mem_wstrb !== cur.wstrb ||
                        (cur.wstrb != 4'h0 && bus_if.mem_wdata !== cur.wdata)) begin
                        bad++;
                        $display("FAIL mem_req: got=addr %h psram %b wstrb %h wdata %h exp=addr %h psram %b wstrb %h wdata %h",
                                 bus_if.mem_addr, bus_if.mem_psram, bus_if.mem_wstrb, bus_if.mem_wdata,
                                 cur.addr, cur.psram, cur.wstrb, cur.wdata);
                    end
                end
                active = 1;
                cnt = mem_delay;
            end
        end
    end

    // Response scoreboard and grant spacing monitor.
    initial begin : monitor
        int r;
        int last_g;
        bit prev_busy;
        rsp_t e;
        logic [1:0] fexp;
        last_g = -1;
        prev_busy = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!resetn) begin
                last_g = -1;
                prev_busy = 0;
            end else begin
                if (busy && !prev_busy) begin
                    if (last_g >= 0) begin
                        total++;
                        if (cyc - last_g < 3) begin
                            bad++;
                            $display("FAIL grant_spacing: got=%0d exp=>=3", cyc - last_g);
                        end
                    end
                    last_g = cyc;
                end
                prev_busy = busy;
                if (bus_if.req_ready != 2'b00) begin
                    total++;
                    if (bus_if.req_ready == 2'b11) begin
                        bad++;
                        $display("FAIL ready_onehot: got=%b exp=one_hot", bus_if.req_ready);
                    end
                    r = bus_if.req_ready[1] ? 1 : 0;
                    order_q.push_back(r);
                    if ((r == 0 && rsp_q0.size() == 0) || (r == 1 && rsp_q1.size() == 0)) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected: got=ready%0d exp=none", r);
                    end else begin
                        e = (r == 0) ? rsp_q0.pop_front() : rsp_q1.pop_front();
                        fexp = e.fault ? ((r == 1) ? 2'b10 : 2'b01) : 2'b00;
                        total++;
                        if (bus_if.req_fault !== fexp) begin
                            bad++;
                            $display("FAIL rsp_fault%0d: got=%b exp=%b", r, bus_if.req_fault, fexp);
                        end
                        total++;
                        if (bus_if.req_rdata !== e.rdata) begin
                            bad++;
                            $display("FAIL rsp_rdata%0d: got=%h exp=%h", r, bus_if.req_rdata, e.rdata);
                        end
                    end
                end
            end
        end
    end

    // qqspi must never see valid in its ready cycle.
    initial begin : overlap
        forever begin
            @(posedge clk);
            #1;
            if (resetn && bus_if.mem_ready) begin
                total++;
                if (bus_if.mem_valid) begin
                    bad++;
                    $display("FAIL valid_in_ready: got=1 exp=0");
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        int exp_order [6];
        exp_order = '{0, 1, 0, 1, 0, 1};

        bus_if.req_valid  = 2'b00;
        bus_if.req_addr0  = '0; bus_if.req_addr1  = '0;
        bus_if.req_wdata0 = '0; bus_if.req_wdata1 = '0;
        bus_if.req_wstrb0 = '0; bus_if.req_wstrb1 = '0;
        bus_if.mem_ready  = 1'b0;
        bus_if.mem_rdata  = '0;
        resetn = 1'b0;

        idle(3);
        chk("rst_mem_valid", {31'h0, bus_if.mem_valid}, 32'h0);
        chk("rst_req_ready", {30'h0, bus_if.req_ready}, 32'h0);
        chk("rst_req_fault", {30'h0, bus_if.req_fault}, 32'h0);
        chk("rst_busy",      {31'h0, busy}, 32'h0);
        chk("rst_req_rdata", bus_if.req_rdata, 32'h0);
        resetn = 1'b1;
        idle(2);

        // PSRAM read, 20-cycle qqspi latency
        mem_delay = 20;
        expect_mem(23'h4, 1'b1, 4'h0, 32'h0, 32'hDEAD_BEEF);
        expect_rsp(0, 1'b0, 32'hDEAD_BEEF);
        req_txn(0, 32'h8000_0010, 32'h0, 4'h0, lat);
        chk("psram_rd_lat", lat, 32'd22);
        idle(3);

        // NOR read from requester 1
        mem_delay = 4;
        expect_mem(23'h41, 1'b0, 4'h0, 32'h0, 32'h1234_5678);
        expect_rsp(1, 1'b0, 32'h1234_5678);
        req_txn(1, 32'h2000_0104, 32'h0, 4'h0, lat);
        chk("nor_rd_lat", lat, 32'd6);
        idle(3);

        // PSRAM write: rdata from qqspi must not leak back
        expect_mem(23'h8, 1'b1, 4'h3, 32'hA5A5_0001, 32'hFFFF_FFFF);
        expect_rsp(0, 1'b0, 32'h0);
        req_txn(0, 32'h8000_0020, 32'hA5A5_0001, 4'h3, lat);
        idle(3);

        // NOR write fault
        expect_rsp(0, 1'b1, 32'h0);
        req_txn(0, 32'h2000_0000, 32'h5555_AAAA, 4'hF, lat);
        chk("nor_wr_fault_lat", lat, 32'd2);
        idle(3);

        // Unmapped, just past PSRAM window
        expect_rsp(1, 1'b1, 32'h0);
        req_txn(1, 32'h8080_0000, 32'h0, 4'h0, lat);
        chk("unmapped_lat", lat, 32'd2);
        idle(3);

        // Window boundaries
        mem_delay = 2;
        expect_mem(23'h1F_FFFF, 1'b1, 4'h0, 32'h0, 32'h0BAD_F00D);
        expect_rsp(0, 1'b0, 32'h0BAD_F00D);
        req_txn(0, 32'h807F_FFFC, 32'h0, 4'h0, lat);
        idle(3);
        expect_mem(23'h3F_FFFF, 1'b0, 4'h0, 32'h0, 32'hC0FF_EE00);
        expect_rsp(1, 1'b0, 32'hC0FF_EE00);
        req_txn(1, 32'h20FF_FFFC, 32'h0, 4'h0, lat);
        idle(3);
        expect_rsp(0, 1'b1, 32'h0);
        req_txn(0, 32'h2100_0000, 32'h0, 4'h0, lat);
        idle(3);
        expect_rsp(1, 1'b1, 32'h0);
        req_txn(1, 32'h1FFF_FFFC, 32'h0, 4'h0, lat);
        idle(3);
        expect_rsp(0, 1'b1, 32'h0);
        req_txn(0, 32'h7FFF_FFFC, 32'h0, 4'h0, lat);
        idle(3);

        // Reset during ISSUE
        mem_delay = 50;
        expect_mem(23'h10, 1'b1, 4'h0, 32'h0, 32'h1111_1111);
        expect_rsp(1, 1'b0, 32'h1111_1111);
        bus_if.req_addr1  = 32'h8000_0040;
        bus_if.req_wstrb1 = 4'h0;
        bus_if.req_valid[1] = 1'b1;
        idle(5);
        chk("issue_busy",      {31'h0, busy}, 32'h1);
        chk("issue_mem_valid", {31'h0, bus_if.mem_valid}, 32'h1);
        resetn = 1'b0;
        bus_if.req_valid = 2'b00;
        @(posedge clk);
        #1;
        chk("midrst_busy",      {31'h0, busy}, 32'h0);
        chk("midrst_mem_valid", {31'h0, bus_if.mem_valid}, 32'h0);
        chk("midrst_req_ready", {30'h0, bus_if.req_ready}, 32'h0);
        rsp_q1.delete();
        mem_q.delete();
        idle(1);

        // Release with both requesters pending: 0 first, then alternate
        mem_delay = 3;
        order_q.delete();
        for (int i = 0; i < 3; i++) begin
            expect_mem(23'h40 + 23'(i), 1'b1, 4'h0, 32'h0, 32'h0A00_0000 + 32'(i));
            expect_mem(23'h80 + 23'(i), 1'b0, 4'h0, 32'h0, 32'h0B00_0000 + 32'(i));
            expect_rsp(0, 1'b0, 32'h0A00_0000 + 32'(i));
            expect_rsp(1, 1'b0, 32'h0B00_0000 + 32'(i));
        end
        resetn = 1'b1;
        fork
            begin
                int l0;
                for (int i = 0; i < 3; i++)
                    req_txn(0, 32'h8000_0100 + 32'(4 * i), 32'h0, 4'h0, l0);
            end
            begin
                int l1;
                for (int j = 0; j < 3; j++)
                    req_txn(1, 32'h2000_0200 + 32'(4 * j), 32'h0, 4'h0, l1);
            end
        join
        idle(3);
        chk("fair_count", order_q.size(), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < order_q.size())
                chk($sformatf("fair_order%0d", k), order_q[k], exp_order[k]);
        end

        idle(3);
        chk("mem_q_empty",  mem_q.size(), 32'd0);
        chk("rsp_q0_empty", rsp_q0.size(), 32'd0);
        chk("rsp_q1_empty", rsp_q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
